// File: rtl/turfio_cin_eyescan.sv
// ============================================================================
//  Module   : turfio_cin_eyescan
//  Purpose  : Automatic delay-scan / centering engine for TURFIO CIN-style
//             deserialised inputs. For each channel (lowest first) it sweeps
//             the input delay taps while a static training pattern is sent.
//             It finds the widest run of error-free taps (the lowest run
//             wins a tie), loads the centre tap, and reports per-channel
//             results.
//  Ports    : rxclk_i            - single clock; all logic in this domain
//             rst_n_i            - asynchronous active-low reset
//             start_i            - one-cycle scan start (ignored while busy)
//             data_i             - ISERDES words, channel c at [c*DWIDTH +: DWIDTH]
//             delay_load_o       - one-cycle load strobe to the addressed delay
//             delay_chan_o       - channel currently addressed
//             delay_cntvaluein_o - tap value presented with the load strobe
//             busy_o / done_o    - scan in progress / one-cycle completion pulse
//             fail_o, tap_o, width_o - per-channel results
//             errcnt_o, errtap_o, errcnt_valid_o - eye-plot stream (optional)
//  Macro    : CIN_EYESCAN_ERRCNT_EN enables the per-tap error counter; when
//             it is undefined the eye-plot ports are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turfio_cin_eyescan #(
  parameter int NCH        = 1,
  parameter int DWIDTH     = 4,
  parameter int DLY_BITS   = 9,
  parameter int STEP       = 8,
  parameter int MAX_TAP    = 511,
  parameter int SETTLE     = 8,   // must be >= 1
  parameter int DWELL_LOG2 = 10
) (
  input  logic                                   rxclk_i,
  input  logic                                   rst_n_i,
  input  logic                                   start_i,
  input  logic [NCH*DWIDTH-1:0]                  data_i,
  output logic                                   delay_load_o,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] delay_chan_o,
  output logic [DLY_BITS-1:0]                    delay_cntvaluein_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic [NCH-1:0]                         fail_o,
  output logic [NCH*DLY_BITS-1:0]                tap_o,
  output logic [NCH*8-1:0]                       width_o,
  output logic [DWELL_LOG2:0]                    errcnt_o,
  output logic [DLY_BITS-1:0]                    errtap_o,
  output logic                                   errcnt_valid_o
);

  localparam int c_CHW = (NCH > 1) ? $clog2(NCH) : 1;
  // One counter serves both SETTLE and SAMPLE; size it for the larger count.
  localparam int c_STW = ($clog2(SETTLE + 1) > DWELL_LOG2 + 1) ? $clog2(SETTLE + 1)
                                                                : DWELL_LOG2 + 1;
  // Width for the centre arithmetic: 8-bit length times a DLY_BITS-wide step.
  localparam int c_CW  = DLY_BITS + 9;

  localparam logic [c_STW-1:0]    c_SETTLE_LAST = c_STW'(SETTLE - 1);
  localparam logic [c_STW-1:0]    c_DWELL_LAST  = c_STW'(1 << DWELL_LOG2);
  localparam logic [DLY_BITS:0]   c_STEP        = (DLY_BITS + 1)'(STEP);
  localparam logic [DLY_BITS:0]   c_MAX_TAP     = (DLY_BITS + 1)'(MAX_TAP);
  localparam logic [c_CHW-1:0]    c_LAST_CH     = c_CHW'(NCH - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LOAD   = 3'd1;
  localparam logic [2:0] c_SETTLE = 3'd2;
  localparam logic [2:0] c_SAMPLE = 3'd3;
  localparam logic [2:0] c_EVAL   = 3'd4;
  localparam logic [2:0] c_CENTER = 3'd5;
  localparam logic [2:0] c_NEXTCH = 3'd6;
  localparam logic [2:0] c_DONE   = 3'd7;

  logic [2:0]              state_q, state_d;
  logic [c_CHW-1:0]        ch_q, ch_d;
  logic [DLY_BITS-1:0]     tap_q, tap_d;
  logic [c_STW-1:0]        cnt_q, cnt_d;
  logic [DWIDTH-1:0]       ref_q, ref_d;
  logic                    mis_q, mis_d;
  logic [DLY_BITS-1:0]     cur_start_q, cur_start_d;
  logic [7:0]              cur_len_q, cur_len_d;
  logic [DLY_BITS-1:0]     best_start_q, best_start_d;
  logic [7:0]              best_len_q, best_len_d;
  logic [NCH-1:0]          fail_q, fail_d;
  logic [NCH*DLY_BITS-1:0] tapres_q, tapres_d;
  logic [NCH*8-1:0]        width_q, width_d;

  logic [DWIDTH-1:0]       word;
  logic                    ref_idle;
  logic                    tap_good;
  logic [DLY_BITS:0]       tap_next;
  logic                    last_pt;
  logic [DLY_BITS-1:0]     run_start;
  logic [7:0]              run_len;
  logic                    close_run;
  logic [c_CW-1:0]         span;
  logic [DLY_BITS-1:0]     center;
  logic                    center_load;

  assign word     = data_i[int'(ch_q)*DWIDTH +: DWIDTH];
  // A constant all-ones/all-zeros word is link idle, not a training pattern.
  assign ref_idle = (ref_q == '0) || (ref_q == '1);
  assign tap_good = !mis_q && !ref_idle;

  // Computed one bit wider so the sweep end is detected without wrap.
  assign tap_next = {1'b0, tap_q} + c_STEP;
  assign last_pt  = tap_next > c_MAX_TAP;

  // Run tracker after folding in the current tap.
  assign run_start = (tap_good && (cur_len_q == 8'd0)) ? tap_q : cur_start_q;
  assign run_len   = !tap_good             ? cur_len_q :
                     (cur_len_q == 8'hFF)  ? 8'hFF     : cur_len_q + 8'd1;
  // The open run also closes at sweep end, so a window touching the last
  // tap still competes for best.
  assign close_run = !tap_good || last_pt;

  assign span   = (c_CW'(best_len_q) - c_CW'(1)) * c_CW'(STEP);
  assign center = DLY_BITS'(c_CW'(best_start_q) + (span >> 1));

  assign center_load = (state_q == c_CENTER) && (best_len_q != 8'd0);

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    ref_d        = ref_q;
    mis_d        = mis_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    fail_d       = fail_q;
    tapres_d     = tapres_q;
    width_d      = width_q;

    case (state_q)
      c_IDLE: begin
        if (start_i) begin
          state_d      = c_LOAD;
          ch_d         = '0;
          tap_d        = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          fail_d       = '0;
          tapres_d     = '0;
          width_d      = '0;
        end
      end
      c_LOAD: begin
        cnt_d   = '0;
        state_d = c_SETTLE;
      end
      c_SETTLE: begin
        if (cnt_q == c_SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = c_SAMPLE;
        end else begin
          cnt_d = cnt_q + c_STW'(1);
        end
      end
      c_SAMPLE: begin
        // Count 0 captures the reference; counts 1..2^DWELL_LOG2 compare.
        if (cnt_q == '0) begin
          ref_d = word;
          mis_d = 1'b0;
        end else if (word != ref_q) begin
          mis_d = 1'b1;
        end
        if (cnt_q == c_DWELL_LAST) begin
          state_d = c_EVAL;
        end else begin
          cnt_d = cnt_q + c_STW'(1);
        end
      end
      c_EVAL: begin
        cur_start_d = run_start;
        if (close_run) begin
          cur_len_d = '0;
          // Strict compare: an equal later window never displaces the first.
          if (run_len > best_len_q) begin
            best_len_d   = run_len;
            best_start_d = run_start;
          end
        end else begin
          cur_len_d = run_len;
        end
        if (last_pt) begin
          state_d = c_CENTER;
        end else begin
          tap_d   = tap_next[DLY_BITS-1:0];
          state_d = c_LOAD;
        end
      end
      c_CENTER: begin
        if (best_len_q == 8'd0) begin
          fail_d[ch_q]                                = 1'b1;
          tapres_d[int'(ch_q)*DLY_BITS +: DLY_BITS]   = '0;
        end else begin
          tapres_d[int'(ch_q)*DLY_BITS +: DLY_BITS]   = center;
        end
        width_d[int'(ch_q)*8 +: 8] = best_len_q;
        state_d                    = c_NEXTCH;
      end
      c_NEXTCH: begin
        if (ch_q == c_LAST_CH) begin
          state_d = c_DONE;
        end else begin
          ch_d         = ch_q + c_CHW'(1);
          tap_d        = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
          state_d      = c_LOAD;
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge rxclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= c_IDLE;
      ch_q         <= '0;
      tap_q        <= '0;
      cnt_q        <= '0;
      ref_q        <= '0;
      mis_q        <= 1'b0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      fail_q       <= '0;
      tapres_q     <= '0;
      width_q      <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      ref_q        <= ref_d;
      mis_q        <= mis_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      fail_q       <= fail_d;
      tapres_q     <= tapres_d;
      width_q      <= width_d;
    end
  end

  assign delay_load_o       = (state_q == c_LOAD) || center_load;
  assign delay_cntvaluein_o = center_load             ? center :
                              (state_q == c_LOAD)     ? tap_q  : '0;
  assign delay_chan_o       = ch_q;
  assign busy_o             = (state_q != c_IDLE);
  assign done_o             = (state_q == c_DONE);
  assign fail_o             = fail_q;
  assign tap_o              = tapres_q;
  assign width_o            = width_q;

`ifdef CIN_EYESCAN_ERRCNT_EN
  logic [DWELL_LOG2:0] errcnt_q;

  always_ff @(posedge rxclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      errcnt_q <= '0;
    end else if (state_q == c_SAMPLE) begin
      if (cnt_q == '0) begin
        errcnt_q <= '0;
      end else if (word != ref_q) begin
        errcnt_q <= errcnt_q + (DWELL_LOG2 + 1)'(1);
      end
    end
  end

  assign errcnt_valid_o = (state_q == c_EVAL);
  // Idle is reported as a fully failing tap so eye plots show it closed.
  assign errcnt_o       = !errcnt_valid_o ? '0 :
                          ref_idle        ? (DWELL_LOG2 + 1)'(1 << DWELL_LOG2) : errcnt_q;
  assign errtap_o       = errcnt_valid_o ? tap_q : '0;
`else
  assign errcnt_valid_o = 1'b0;
  assign errcnt_o       = '0;
  assign errtap_o       = '0;
`endif

endmodule

`default_nettype wire

// File: doc/turfio_cin_eyescan.md
Name: turfio_cin_eyescan

Overview:
- Parametrised, multi-channel automatic delay-scan/centering engine for TURFIO CIN-style deserialised inputs. It is the successor to the single-channel manual delay-load capture path.
- For each channel it sweeps the input delay tap range while a static training pattern is sent, and finds the widest run of error-free taps. It then loads the centre tap and reports per-channel results.
- Sits in the rxclk domain, between the per-channel ISERDES outputs and the IDELAY LOAD/CNTVALUEIN controls.

Parameters:
- NCH, 1: number of input channels scanned, one at a time, lowest first.
- DWIDTH, 4: deserialised word width per channel (4 or 8).
- DLY_BITS, 9: delay tap value width.
- STEP, 8: tap increment between test points (power of 2, ≥1).
- MAX_TAP, 511: last tap tested (≤ 2^DLY_BITS−1).
- SETTLE, 8: cycles waited after each load before sampling.
- DWELL_LOG2, 10: 2^DWELL_LOG2 words compared per tap.

Ports:
- rxclk_i  in  1  single clock; all logic is in this domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle start of a full scan; ignored while busy_o=1.
- data_i  in  NCH*DWIDTH  ISERDES words; channel c occupies [c*DWIDTH +: DWIDTH].
- delay_load_o  out  1  one-cycle load strobe to the delay of channel delay_chan_o.
- delay_chan_o  out  max(1,$clog2(NCH))  channel currently addressed.
- delay_cntvaluein_o  out  DLY_BITS  tap value presented with the load strobe.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse when all channels have finished.
- fail_o  out  NCH  per channel: no error-free tap was found.
- tap_o  out  NCH*DLY_BITS  per channel: final centred tap.
- width_o  out  NCH*8  per channel: best window length in test points, saturating at 255.

Behaviour:
- Reset values: every output is 0; the FSM is in IDLE.
- Reset is asynchronous. Asserting it mid-scan aborts immediately and emits no done_o. Previous results are cleared.
- FSM states: IDLE, LOAD, SETTLE, SAMPLE, EVAL, CENTER, NEXTCH, DONE.
- IDLE: on start_i, set busy_o=1, channel=0, tap=0, clear window trackers, go to LOAD.
- LOAD: delay_load_o=1 for exactly one cycle with delay_cntvaluein_o=tap. Go to SETTLE.
- SETTLE: count SETTLE cycles, then go to SAMPLE.
- SAMPLE:
  - The first word is captured as ref.
  - Over the following 2^DWELL_LOG2 cycles, a mismatch flag is set if any word ≠ ref.
  - The tap is "good" iff the flag is clear and ref is neither all-ones nor all-zeros (idle is not a valid pattern).
- EVAL (one cycle):
  - Good tap: if this is the first tap of a run, cur_start=tap. Then cur_len++ (saturating at 255).
  - Bad tap: close the current run.
  - Close rule: if cur_len > best_len, copy cur_start/cur_len into best_start/best_len. The comparison is strict, so on a tie the lowest window wins. Then clear cur_len.
  - If tap+STEP > MAX_TAP, close the open run and go to CENTER. Otherwise tap += STEP (computed in DLY_BITS+1 bits, with no wrap) and go to LOAD.
- CENTER (one cycle):
  - If best_len=0: fail_o[ch]=1, tap_o[ch]=0, and no load is issued.
  - Otherwise: tap_o[ch] = best_start + (((best_len−1)*STEP)>>1), truncated to DLY_BITS. Issue one delay_load_o with that value.
  - In both cases, width_o[ch]=best_len. Go to NEXTCH.
- NEXTCH: if ch = NCH−1, go to DONE. Otherwise ch++, tap=0, clear trackers, go to LOAD.
- DONE: done_o=1 for one cycle, busy_o→0, return to IDLE. Results hold until the next start_i or reset.
- A new start_i clears fail_o, tap_o and width_o for all channels at scan start.
- delay_chan_o holds the current channel for the whole per-channel sweep, including CENTER.
- Per-tap latency: 1 (LOAD) + SETTLE + 1 + 2^DWELL_LOG2 + 1 (EVAL) cycles.

Optional Feature:
- Macro: CIN_EYESCAN_ERRCNT_EN.
- When defined:
  - Adds errcnt_o (DWELL_LOG2+1 bits), the count of mismatching words at the tap.
  - Adds errtap_o (DLY_BITS) and errcnt_valid_o, a one-cycle strobe in EVAL. This gives an eye-plot stream; an idle pattern reports errcnt = 2^DWELL_LOG2.
- When not defined: the ports still exist, tied to 0, and no counter logic is generated.

Test Plan:
- NCH=1, STEP=8, MAX_TAP=511, data constant 4'hA at taps 64..191 and toggling elsewhere; start_i → 64 LOAD strobes then a centre load of tap 124, width_o=16, fail_o=0, done_o pulses once.
- Data stuck at 4'hF (idle) at all taps → fail_o=1, tap_o=0, width_o=0, and no centre load is issued.
- Two good windows, taps 0..31 (4 points) and 200..231 (4 points) → tie resolves to the lower window, tap_o=12.
- Good window extending to tap 504 (the last point), starting at 440 → window closed at sweep end, width_o=9, tap_o=472.
- NCH=3, DWIDTH=8, with distinct windows per channel → channels scanned 0,1,2 in order, delay_chan_o matches each channel's strobes, all three results correct, and exactly one done_o.
- rst_n_i pulsed low mid-SAMPLE of channel 1 → all outputs 0 asynchronously, no done_o; start_i asserted during busy is ignored (no restart).
